// File: rtl/tlb_fill_cache.sv
// Translation cache fed by two page-table-walker response channels.
// Fills are arbitrated round-robin; lookups return a registered hit/ppn/error one cycle later.
module tlb_fill_cache #(
   parameter int ENTRIES = 4,
   parameter int VPN_W   = 20,
   parameter int PPN_W   = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           fill0_valid,
   output logic                           fill0_ready,
   input  logic [VPN_W-1:0]               fill0_vpn,
   input  logic [PPN_W-1:0]               fill0_ppn,
   input  logic                           fill0_error,
   input  logic                           fill1_valid,
   output logic                           fill1_ready,
   input  logic [VPN_W-1:0]               fill1_vpn,
   input  logic [PPN_W-1:0]               fill1_ppn,
   input  logic                           fill1_error,
   input  logic                           lookup_valid,
   input  logic [VPN_W-1:0]               lookup_vpn,
   output logic                           resp_valid,
   output logic                           resp_hit,
   output logic [PPN_W-1:0]               resp_ppn,
   output logic                           resp_error,
   output logic [$clog2(ENTRIES+1)-1:0]   count
);

   localparam int PTR_W = $clog2(ENTRIES);
   localparam int CNT_W = $clog2(ENTRIES+1);

   logic [ENTRIES-1:0] valid_r;
   logic [VPN_W-1:0]   vpn_r [ENTRIES];
   logic [PPN_W-1:0]   ppn_r [ENTRIES];
   logic [ENTRIES-1:0] err_r;
   logic [PTR_W-1:0]   vptr_r;
   logic               rr_r;
   logic [CNT_W-1:0]   count_r;

   logic               grant0_s, grant1_s, accept_s;
   logic [VPN_W-1:0]   sel_vpn_s;
   logic [PPN_W-1:0]   sel_ppn_s;
   logic               sel_err_s;
   logic [ENTRIES-1:0] fill_match_s, lk_match_s;
   logic [PTR_W-1:0]   fill_idx_s, lk_idx_s, wr_idx_s;
   logic               fill_hit_s, lk_hit_s;

   // rr_r holds the last granted channel; the other one wins a tie
   assign grant0_s    = fill0_valid & (~fill1_valid | rr_r);
   assign grant1_s    = fill1_valid & (~fill0_valid | ~rr_r);
   assign fill0_ready = grant0_s & ~flush & ~reset;
   assign fill1_ready = grant1_s & ~flush & ~reset;
   assign accept_s    = fill0_ready | fill1_ready;
   assign sel_vpn_s   = fill1_ready ? fill1_vpn   : fill0_vpn;
   assign sel_ppn_s   = fill1_ready ? fill1_ppn   : fill0_ppn;
   assign sel_err_s   = fill1_ready ? fill1_error : fill0_error;
   assign count       = count_r;

   // Tag compare for the fill and lookup paths; at most one entry can match each
   always_comb begin
      fill_idx_s = '0;
      lk_idx_s   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         fill_match_s[i] = valid_r[i] & (vpn_r[i] == sel_vpn_s);
         lk_match_s[i]   = valid_r[i] & (vpn_r[i] == lookup_vpn);
         fill_idx_s      = fill_idx_s | (PTR_W'(i) & {PTR_W{fill_match_s[i]}});
         lk_idx_s        = lk_idx_s   | (PTR_W'(i) & {PTR_W{lk_match_s[i]}});
      end
   end

   assign fill_hit_s = |fill_match_s;
   assign lk_hit_s   = |lk_match_s;
   assign wr_idx_s   = fill_hit_s ? fill_idx_s : vptr_r;

   // Entry payload; validity is tracked separately so this needs no reset
   always_ff @(posedge clk) begin
      if (accept_s) begin
         vpn_r[wr_idx_s] <= sel_vpn_s;
         ppn_r[wr_idx_s] <= sel_ppn_s;
         err_r[wr_idx_s] <= sel_err_s;
      end
   end

   // Valid bits, FIFO victim pointer, population count and arbiter state
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= '0;
         vptr_r  <= '0;
         count_r <= '0;
         rr_r    <= 1'b1;
      end else if (flush) begin
         valid_r <= '0;
         vptr_r  <= '0;
         count_r <= '0;
      end else if (accept_s) begin
         valid_r[wr_idx_s] <= 1'b1;
         rr_r              <= fill1_ready;
         if (!fill_hit_s) begin
            // when full, entry[vptr] is the oldest fill and is simply replaced
            vptr_r <= vptr_r + PTR_W'(1);
            if (count_r != CNT_W'(ENTRIES)) begin
               count_r <= count_r + CNT_W'(1);
            end
         end
      end
   end

   // Registered lookup response, evaluated against pre-edge contents
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_ppn   <= '0;
         resp_error <= 1'b0;
      end else begin
         resp_valid <= lookup_valid;
         resp_hit   <= lookup_valid & lk_hit_s;
         resp_ppn   <= (lookup_valid & lk_hit_s) ? ppn_r[lk_idx_s] : '0;
         resp_error <= lookup_valid & lk_hit_s & err_r[lk_idx_s];
      end
   end

endmodule

// File: tb/tb_tlb_fill_cache.sv
// Directed self-checking bench for tlb_fill_cache with the default ENTRIES=4 geometry.
module tb_tlb_fill_cache;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        fill0_valid, fill0_ready, fill0_error;
   logic        fill1_valid, fill1_ready, fill1_error;
   logic [19:0] fill0_vpn, fill1_vpn, lookup_vpn;
   logic [31:0] fill0_ppn, fill1_ppn, resp_ppn;
   logic        lookup_valid, resp_valid, resp_hit, resp_error;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tlb_fill_cache #(.ENTRIES(4), .VPN_W(20), .PPN_W(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .fill0_valid(fill0_valid), .fill0_ready(fill0_ready), .fill0_vpn(fill0_vpn),
      .fill0_ppn(fill0_ppn), .fill0_error(fill0_error),
      .fill1_valid(fill1_valid), .fill1_ready(fill1_ready), .fill1_vpn(fill1_vpn),
      .fill1_ppn(fill1_ppn), .fill1_error(fill1_error),
      .lookup_valid(lookup_valid), .lookup_vpn(lookup_vpn),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_ppn(resp_ppn),
      .resp_error(resp_error), .count(count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one lookup cycle, response checked one cycle later
   task automatic look(input string tag, input logic [19:0] vpn, input logic hit,
                       input logic [31:0] ppn, input logic err);
      lookup_valid = 1'b1;
      lookup_vpn   = vpn;
      tick();
      lookup_valid = 1'b0;
      chk({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, ".hit"},   {31'd0, resp_hit},   {31'd0, hit});
      chk({tag, ".ppn"},   resp_ppn,            ppn);
      chk({tag, ".err"},   {31'd0, resp_error}, {31'd0, err});
   endtask

   task automatic fill0(input logic [19:0] vpn, input logic [31:0] ppn);
      fill0_valid = 1'b1; fill0_vpn = vpn; fill0_ppn = ppn; fill0_error = 1'b0;
      #1;
      chk("fill0.ready", {31'd0, fill0_ready}, 32'd1);
      tick();
      fill0_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; lookup_valid = 1'b0; lookup_vpn = 20'd0;
      fill0_valid = 1'b1; fill0_vpn = 20'd0; fill0_ppn = 32'd0; fill0_error = 1'b0;
      fill1_valid = 1'b0; fill1_vpn = 20'd0; fill1_ppn = 32'd0; fill1_error = 1'b0;
      tick(); tick();
      chk("rst.ready0", {31'd0, fill0_ready}, 32'd0);
      chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst.resp_ppn", resp_ppn, 32'd0);
      chk("rst.count", {29'd0, count}, 32'd0);
      fill0_valid = 1'b0;
      reset = 1'b0;
      tick();

      look("empty", 20'h00010, 1'b0, 32'd0, 1'b0);
      chk("empty.count", {29'd0, count}, 32'd0);
      tick();
      chk("idle.resp_valid", {31'd0, resp_valid}, 32'd0);

      // no bypass: lookup in the fill cycle misses
      lookup_valid = 1'b1; lookup_vpn = 20'h00010;
      fill0(20'h00010, 32'hABCD0000);
      lookup_valid = 1'b0;
      chk("nobyp.hit", {31'd0, resp_hit}, 32'd0);
      chk("nobyp.count", {29'd0, count}, 32'd1);
      look("fill1st", 20'h00010, 1'b1, 32'hABCD0000, 1'b0);

      // reset restores channel-0 tie priority
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst2.count", {29'd0, count}, 32'd0);

      // both channels pending: grants alternate 0,1,0,1
      fill0_valid = 1'b1; fill0_vpn = 20'h00100; fill0_ppn = 32'h00001100;
      fill1_valid = 1'b1; fill1_vpn = 20'h00200; fill1_ppn = 32'h00001200;
      #1;
      chk("arb1.r0", {31'd0, fill0_ready}, 32'd1);
      chk("arb1.r1", {31'd0, fill1_ready}, 32'd0);
      tick();
      fill0_vpn = 20'h00101; fill0_ppn = 32'h00001101;
      #1;
      chk("arb2.r0", {31'd0, fill0_ready}, 32'd0);
      chk("arb2.r1", {31'd0, fill1_ready}, 32'd1);
      tick();
      fill1_vpn = 20'h00201; fill1_ppn = 32'h00001201;
      #1;
      chk("arb3.r0", {31'd0, fill0_ready}, 32'd1);
      chk("arb3.r1", {31'd0, fill1_ready}, 32'd0);
      tick();
      fill0_valid = 1'b0;
      #1;
      chk("arb4.r1", {31'd0, fill1_ready}, 32'd1);
      tick();
      fill1_valid = 1'b0;
      chk("arb.count", {29'd0, count}, 32'd4);
      look("arb.a", 20'h00100, 1'b1, 32'h00001100, 1'b0);
      look("arb.b", 20'h00200, 1'b1, 32'h00001200, 1'b0);
      look("arb.c", 20'h00101, 1'b1, 32'h00001101, 1'b0);
      look("arb.d", 20'h00201, 1'b1, 32'h00001201, 1'b0);

      // flush refuses the fill; same-cycle lookup sees pre-flush contents
      flush = 1'b1; fill0_valid = 1'b1; fill0_vpn = 20'h00300;
      lookup_valid = 1'b1; lookup_vpn = 20'h00100;
      #1;
      chk("flush.ready0", {31'd0, fill0_ready}, 32'd0);
      tick();
      flush = 1'b0; fill0_valid = 1'b0; lookup_valid = 1'b0;
      chk("flush.prehit", {31'd0, resp_hit}, 32'd1);
      chk("flush.count", {29'd0, count}, 32'd0);
      look("flush.miss", 20'h00100, 1'b0, 32'd0, 1'b0);
      look("flush.miss300", 20'h00300, 1'b0, 32'd0, 1'b0);

      // FIFO replacement: vpn 5 evicts vpn 1
      for (int v = 1; v <= 5; v++) fill0(20'(v), 32'(v * 16));
      chk("fifo.count", {29'd0, count}, 32'd4);
      look("fifo.v1", 20'd1, 1'b0, 32'd0, 1'b0);
      for (int v = 2; v <= 5; v++) look("fifo.hit", 20'(v), 1'b1, 32'(v * 16), 1'b0);
      fill0(20'd3, 32'h00000055);
      chk("refill.count", {29'd0, count}, 32'd4);
      look("refill.v3", 20'd3, 1'b1, 32'h00000055, 1'b0);
      look("refill.v2", 20'd2, 1'b1, 32'h00000020, 1'b0);

      // error fill on channel 1 evicts vpn 2 (oldest)
      fill1_valid = 1'b1; fill1_vpn = 20'h00007; fill1_ppn = 32'h00000077; fill1_error = 1'b1;
      #1;
      chk("err.ready1", {31'd0, fill1_ready}, 32'd1);
      tick();
      fill1_valid = 1'b0; fill1_error = 1'b0;
      look("err.v7", 20'h00007, 1'b1, 32'h00000077, 1'b1);
      look("err.v2gone", 20'd2, 1'b0, 32'd0, 1'b0);

      // same vpn on both channels: ch0 wins tie, ch1 overwrites in place next cycle
      fill0_valid = 1'b1; fill0_vpn = 20'h00009; fill0_ppn = 32'h00000090;
      fill1_valid = 1'b1; fill1_vpn = 20'h00009; fill1_ppn = 32'h00000091;
      #1;
      chk("dup.r0", {31'd0, fill0_ready}, 32'd1);
      chk("dup.r1", {31'd0, fill1_ready}, 32'd0);
      tick();
      fill0_valid = 1'b0;
      #1;
      chk("dup2.r1", {31'd0, fill1_ready}, 32'd1);
      tick();
      fill1_valid = 1'b0;
      chk("dup.count", {29'd0, count}, 32'd4);
      look("dup.v9", 20'h00009, 1'b1, 32'h00000091, 1'b0);
      look("dup.v3gone", 20'd3, 1'b0, 32'd0, 1'b0);
      look("dup.v4", 20'd4, 1'b1, 32'h00000040, 1'b0);

      // reset mid-stream drops the fill and clears everything
      reset = 1'b1; fill0_valid = 1'b1; fill0_vpn = 20'h0000A;
      lookup_valid = 1'b1; lookup_vpn = 20'h00009;
      #1;
      chk("mid.ready0", {31'd0, fill0_ready}, 32'd0);
      tick();
      reset = 1'b0; fill0_valid = 1'b0; lookup_valid = 1'b0;
      chk("mid.resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("mid.resp_hit", {31'd0, resp_hit}, 32'd0);
      chk("mid.resp_ppn", resp_ppn, 32'd0);
      chk("mid.count", {29'd0, count}, 32'd0);
      look("mid.v9", 20'h00009, 1'b0, 32'd0, 1'b0);
      look("mid.vA", 20'h0000A, 1'b0, 32'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tlb_fill_cache.md
# tlb_fill_cache

Parametrised translation cache sitting between the two page-table-walker response channels (imem, dmem) and the address-translation lookup path. It arbitrates fills from both channels, stores up to ENTRIES vpn→ppn mappings with per-entry valid and error bits, and answers lookups with one-cycle registered hit/ppn/error. It replaces the fixed two-entry, single-channel, unarbitrated tag store of the previous generation.

## Interface
- ENTRIES, 4, number of mappings; power of two, ≥2
- VPN_W, 20, virtual page number width
- PPN_W, 32, physical page number width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  invalidate all entries this cycle
- fill0_valid / fill1_valid  in  1  imem / dmem PTW response valid
- fill0_ready / fill1_ready  out  1  fill accepted this cycle (combinational)
- fill0_vpn / fill1_vpn  in  VPN_W  tag of fill
- fill0_ppn / fill1_ppn  in  PPN_W  translation of fill
- fill0_error / fill1_error  in  1  walk faulted
- lookup_valid  in  1  lookup request
- lookup_vpn  in  VPN_W  tag to look up
- resp_valid  out  1  registered lookup result valid
- resp_hit  out  1  match found
- resp_ppn  out  PPN_W  matched ppn, 0 on miss
- resp_error  out  1  matched entry's error bit, 0 on miss
- count  out  clog2(ENTRIES+1)  number of valid entries

## Operation
- Storage: ENTRIES × {valid, vpn, ppn, error}; victim pointer vptr (log2 ENTRIES bits); arbiter priority bit rr.
- Arbitration: at most one fill accepted per cycle. Only one valid → it wins. Both valid → channel ≠ last granted wins; rr flips to the granted channel after each accepted fill. After reset channel 0 wins a tie.
- ready = grant & !flush & !reset; non-granted channel sees ready=0 and must hold.
- Fill write: if accepted vpn matches a valid entry, overwrite that entry in place (no duplicates), vptr unchanged. Otherwise write entry[vptr], set valid, vptr ← vptr+1 mod ENTRIES (wraps ENTRIES-1→0). When full, oldest-filled entry is overwritten (FIFO replacement).
- Error fills are stored; a later lookup hits with resp_error=1.
- Flush: clears all valid bits, vptr ← 0; rr unchanged; fills refused that cycle. Lookup issued in the flush cycle is evaluated against pre-flush contents.
- Lookup: compare lookup_vpn to all valid entries; at most one can match. Result registered.
- count: population of valid bits; increments only on fill to a non-matching entry while not full; saturates at ENTRIES.
- Reset: all valids 0, vptr 0, rr → channel 0 priority, resp_valid/resp_hit/resp_error 0, resp_ppn 0, count 0. Reset mid-fill drops the fill.

## Timing
- Lookup latency 1: lookup_valid at cycle N → resp_* valid at N+1; resp_valid=0 in cycles with no lookup at N (other resp_* then 0).
- No bypass: lookup at cycle N of a vpn filled at cycle N misses; lookup at N+1 hits.
- Fill write visible at edge ending the accept cycle; count updates same edge.
- Back-to-back lookups every cycle supported; fills and lookups proceed in parallel.
- Simultaneous fill of same vpn on both channels: one accepted, other accepted next cycle and overwrites in place.

## Test plan
- Reset, then lookup vpn 0x00010 → next cycle resp_valid=1, hit=0, ppn=0, error=0; count=0.
- Fill0 vpn 0x00010 ppn 0xABCD0000; lookup same cycle → miss; lookup next cycle → hit, ppn 0xABCD0000; count=1.
- Both channels valid for 4 cycles with distinct vpns → grants alternate 0,1,0,1; stalled channel held with ready=0; all four hit afterward.
- ENTRIES=4: fill vpns 1..5 → count saturates at 4, vpn 1 misses, vpns 2..5 hit; refill vpn 3 with ppn 0x55 → count 4, vpn 3 returns 0x55, vpn 2 still hits.
- Fill1 vpn 0x7 error=1 → lookup hit=1, error=1.
- Assert flush with fill0_valid=1 → fill0_ready=0, count→0, all lookups miss next cycle; reset asserted mid-stream → all outputs return to reset values.
